// File: rtl/mci_reg_pkg.sv
// Shared constants and types for the MCI register responder.
// Word indices are byte offsets >> 2.
package mci_reg_pkg;

   localparam int INT_W = 8;
   localparam int CNT_W = 4;

   localparam logic [11:0] W_CTRL    = 12'h000;
   localparam logic [11:0] W_MAC_LO  = 12'h001;
   localparam logic [11:0] W_MAC_HI  = 12'h002;
   localparam logic [11:0] W_STATUS  = 12'h003;
   localparam logic [11:0] W_INTSTAT = 12'h004;
   localparam logic [11:0] W_INTMASK = 12'h005;
   localparam logic [11:0] W_SCRATCH = 12'h006;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_ACK,
      ST_DONE
   } mci_state_t;

   typedef struct packed {
      logic [11:0] word;
      logic        rdwn;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mci_req_t;

   function automatic logic is_mapped(input logic [11:0] word);
      return word <= W_SCRATCH;
   endfunction

   function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                            input logic [31:0] wd,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = cur;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/mci_reg_file.sv
// MAC config register bank: decode, byte-enabled writes, INT_STAT W1C/set,
// read mux and the registered interrupt line.
module mci_reg_file
   import mci_reg_pkg::*;
#(
   parameter logic [31:0] CTRL_RST      = 32'h0000_0000,
   parameter logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_en,
   input  logic [11:0]       i_wr_word,
   input  logic [31:0]       i_wdata,
   input  logic [3:0]        i_be,
   input  logic [11:0]       i_rd_word,
   output logic [31:0]       o_rd_data,
   input  logic [31:0]       i_status,
   input  logic [INT_W-1:0]  i_int_set,
   output logic [31:0]       o_ctrl,
   output logic [47:0]       o_mac_addr,
   output logic              o_irq
);

   logic [31:0]      ctrl_q, mac_lo_q, scratch_q;
   logic [15:0]      mac_hi_q;
   logic [INT_W-1:0] int_stat_q, int_mask_q, w1c;

   always_comb begin
      w1c = '0;
      if (i_wr_en && i_wr_word == W_INTSTAT && i_be[0])
         w1c = i_wdata[INT_W-1:0];
   end

   // Set is OR'd after the clear so a coincident set pulse wins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ctrl_q     <= CTRL_RST;
         mac_lo_q   <= '0;
         mac_hi_q   <= '0;
         scratch_q  <= '0;
         int_stat_q <= '0;
         int_mask_q <= '0;
         o_irq      <= 1'b0;
      end else begin
         int_stat_q <= (int_stat_q & ~w1c) | i_int_set;
         o_irq      <= |(int_stat_q & int_mask_q);
         if (i_wr_en) begin
            case (i_wr_word)
               W_CTRL:    ctrl_q    <= be_merge(ctrl_q, i_wdata, i_be);
               W_MAC_LO:  mac_lo_q  <= be_merge(mac_lo_q, i_wdata, i_be);
               W_SCRATCH: scratch_q <= be_merge(scratch_q, i_wdata, i_be);
               W_MAC_HI: begin
                  if (i_be[0]) mac_hi_q[7:0]  <= i_wdata[7:0];
                  if (i_be[1]) mac_hi_q[15:8] <= i_wdata[15:8];
               end
               W_INTMASK: if (i_be[0]) int_mask_q <= i_wdata[INT_W-1:0];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      o_rd_data = DEFAULT_RDATA;
      case (i_rd_word)
         W_CTRL:    o_rd_data = ctrl_q;
         W_MAC_LO:  o_rd_data = mac_lo_q;
         W_MAC_HI:  o_rd_data = {16'h0, mac_hi_q};
         W_STATUS:  o_rd_data = i_status;
         W_INTSTAT: o_rd_data = {{(32-INT_W){1'b0}}, int_stat_q};
         W_INTMASK: o_rd_data = {{(32-INT_W){1'b0}}, int_mask_q};
         W_SCRATCH: o_rd_data = scratch_q;
         default:   o_rd_data = DEFAULT_RDATA;
      endcase
   end

   assign o_ctrl     = ctrl_q;
   assign o_mac_addr = {mac_hi_q, mac_lo_q};

endmodule

// File: rtl/mci_reg_slave.sv
// MCI responder: request latch, ack-latency FSM, registered read data.
// Optional MCI_ERR_EN adds o_mci_err for unmapped accesses and STATUS writes.
module mci_reg_slave
   import mci_reg_pkg::*;
#(
   parameter int          ACK_LAT       = 1,
   parameter logic [31:0] CTRL_RST      = 32'h0000_0000,
   parameter logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_mci_val,
   input  logic [13:0]       i_mci_addr,
   input  logic              i_mci_rdwn,
   input  logic [31:0]       i_mci_wdata,
   input  logic [3:0]        i_mci_be,
   output logic              o_mci_ack,
   output logic [31:0]       o_mci_rdata,
   output logic [31:0]       o_ctrl,
   output logic [47:0]       o_mac_addr,
   input  logic [31:0]       i_status,
   input  logic [INT_W-1:0]  i_int_set,
   output logic              o_irq
`ifdef MCI_ERR_EN
   ,
   output logic              o_mci_err
`endif
);

   mci_state_t       state, nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   mci_req_t         req_q;
   logic             lat_en, rd_load, rd_is_read, wr_en;
   logic [11:0]      rd_word;
   logic [31:0]      rd_data;
   logic             unused_addr_lsb;

   assign unused_addr_lsb = ^i_mci_addr[1:0];

   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      lat_en  = 1'b0;
      case (state)
         ST_IDLE:
            if (i_mci_val) begin
               lat_en = 1'b1;
               if (ACK_LAT == 1) begin
                  nxt = ST_ACK;
               end else begin
                  nxt     = ST_BUSY;
                  cnt_nxt = CNT_W'(ACK_LAT - 1);
               end
            end
         ST_BUSY:
            if (!i_mci_val) begin
               nxt     = ST_IDLE;
               cnt_nxt = '0;
            end else if (cnt == CNT_W'(1)) begin
               nxt     = ST_ACK;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         ST_ACK:  nxt = ST_DONE;
         ST_DONE: if (!i_mci_val) nxt = ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
   end

   // With ACK_LAT==1 the ACK state follows IDLE directly, so the read mux
   // must look at the live request while the latch is being loaded.
   assign rd_word    = (state == ST_IDLE) ? i_mci_addr[13:2] : req_q.word;
   assign rd_is_read = (state == ST_IDLE) ? i_mci_rdwn : req_q.rdwn;
   assign rd_load    = (nxt == ST_ACK) && rd_is_read;
   assign wr_en      = (state == ST_ACK) && !req_q.rdwn;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         req_q       <= '0;
         o_mci_rdata <= '0;
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
         if (lat_en)
            req_q <= '{word: i_mci_addr[13:2], rdwn: i_mci_rdwn,
                       wdata: i_mci_wdata, be: i_mci_be};
         if (rd_load)
            o_mci_rdata <= rd_data;
      end
   end

   assign o_mci_ack = (state == ST_ACK);

`ifdef MCI_ERR_EN
   assign o_mci_err = (state == ST_ACK) &&
                      (!is_mapped(req_q.word) || (!req_q.rdwn && req_q.word == W_STATUS));
`endif

   mci_reg_file #(
      .CTRL_RST      (CTRL_RST),
      .DEFAULT_RDATA (DEFAULT_RDATA)
   ) u_regs (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_wr_en    (wr_en),
      .i_wr_word  (req_q.word),
      .i_wdata    (req_q.wdata),
      .i_be       (req_q.be),
      .i_rd_word  (rd_word),
      .o_rd_data  (rd_data),
      .i_status   (i_status),
      .i_int_set  (i_int_set),
      .o_ctrl     (o_ctrl),
      .o_mac_addr (o_mac_addr),
      .o_irq      (o_irq)
   );

endmodule
